// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: walks instruction memory, decodes the
// 3-bit opcode and issues ALU, data-memory and register-file strobes one phase at a time.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start; pc reloads from base_pc on start
// S_FETCH     | imem_req held until imem_ack, instruction latched on ack
// S_DECODE    | one quiet cycle; NOP advances pc and refetches
// S_EXECUTE   | alu_enable for one cycle
// S_MEM       | mem_read / mem_write held until dmem_ack
// S_WRITEBACK | reg_write for one cycle, pc advances
// S_HALT      | done for one cycle, then back to idle
module core_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               dmem_ack,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               alu_enable,
  output logic [1:0]         alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic [2:0]           w_opcode;
  logic                 w_is_alu;
  logic                 w_is_mem;
  logic [ADDR_W-1:0]    w_pc_inc;

  assign w_opcode = r_instr[INSTR_W-1 -: 3];
  assign w_is_alu = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) || (w_opcode == OP_AND);
  assign w_is_mem = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE);
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_FETCH;
      S_FETCH:     if (imem_ack) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_alu)                  w_next = S_EXECUTE;
        else if (w_is_mem)             w_next = S_MEM;
        else if (w_opcode == OP_HALT)  w_next = S_HALT;
        else                           w_next = S_FETCH;
      end
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_MEM:       if (dmem_ack) w_next = (w_opcode == OP_LOAD) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: w_next = S_FETCH;
      S_HALT:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // pc advances on NOP decode, STORE completion and every writeback; HALT leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      case (r_state)
        S_IDLE:      if (start) r_pc <= base_pc;
        S_FETCH:     if (imem_ack) r_instr <= imem_rdata;
        S_DECODE:    if (!w_is_alu && !w_is_mem && (w_opcode != OP_HALT)) r_pc <= w_pc_inc;
        S_MEM:       if (dmem_ack && (w_opcode == OP_STORE)) r_pc <= w_pc_inc;
        S_WRITEBACK: r_pc <= w_pc_inc;
        default:     r_pc <= r_pc;
      endcase
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    alu_enable = 1'b0;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_FETCH:     imem_req = 1'b1;
      S_EXECUTE: begin
        alu_enable = 1'b1;
        alu_op     = w_opcode[1:0];
      end
      S_MEM: begin
        mem_read  = (w_opcode == OP_LOAD);
        mem_write = (w_opcode == OP_STORE);
      end
      S_WRITEBACK: reg_write = 1'b1;
      S_HALT:      done = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: memory responders with programmable ack delay,
// a strobe monitor, and one task per scenario with hand-computed expectations.
module tb_core_sequencer;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011, OP_STORE = 3'b100, OP_NOP = 3'b101, OP_HALT = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_pc = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        dmem_ack = 1'b0;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        alu_enable;
  logic [1:0]  alu_op;
  logic        mem_read, mem_write, reg_write, busy, done;

  core_sequencer #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_pc(base_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_ack(dmem_ack), .instr(instr), .pc(pc), .alu_enable(alu_enable), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [0:255];
  int idelay = 0, ddelay = 0;
  logic dspur = 1'b0;
  int checks = 0, failures = 0;

  // monitor counters (written only by the monitor)
  int cyc = 0, n_alu = 0, n_rw = 0, n_rw_bad = 0, n_mr = 0, n_mw = 0, n_bad = 0;
  int n_done = 0, done_cyc = 0, req_run = 0, last_req_run = 0, unstable = 0;
  logic [5:0] op_log = 6'h0;
  logic [7:0] fa0 = 8'h0, fa1 = 8'h0;

  function automatic logic [15:0] ins(input logic [2:0] op);
    return {op, 13'h0A5};
  endfunction

  // memory responders: ack after the programmed number of wait cycles
  initial begin : responder
    int icnt, dcnt;
    logic dreal;
    icnt = 0; dcnt = 0;
    forever begin
      @(negedge clk);
      dreal = 1'b0;
      if (imem_req) begin
        if (icnt >= idelay) begin imem_ack = 1'b1; imem_rdata = imem[imem_addr]; icnt = 0; end
        else begin imem_ack = 1'b0; icnt++; end
      end else begin
        imem_ack = 1'b0; icnt = 0;
      end
      if (mem_read || mem_write) begin
        if (dcnt >= ddelay) begin dreal = 1'b1; dcnt = 0; end
        else dcnt++;
      end else dcnt = 0;
      dmem_ack = dreal | dspur;
    end
  end

  initial begin : monitor
    logic p_alu, p_dack, p_req, p_iack, p_mr, p_mw;
    logic [7:0] p_addr;
    p_alu = 0; p_dack = 0; p_req = 0; p_iack = 0; p_mr = 0; p_mw = 0; p_addr = 0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (alu_enable) begin n_alu++; op_log = {op_log[3:0], alu_op}; end
      if (!alu_enable && alu_op != 2'b00) n_bad++;
      if (mem_read && mem_write) n_bad++;
      if (reg_write) begin n_rw++; if (!(p_alu || p_dack)) n_rw_bad++; end
      if (mem_read) n_mr++;
      if (mem_write) n_mw++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (imem_req && imem_ack) begin fa1 = fa0; fa0 = imem_addr; end
      if (imem_req) req_run++;
      else if (p_req) begin last_req_run = req_run; req_run = 0; end
      if (rst_n) begin
        if (p_req && !p_iack && (!imem_req || imem_addr != p_addr)) unstable++;
        if (p_mr && !p_dack && !mem_read) unstable++;
        if (p_mw && !p_dack && !mem_write) unstable++;
        p_alu = alu_enable; p_dack = dmem_ack && (mem_read || mem_write);
        p_req = imem_req; p_iack = imem_ack; p_addr = imem_addr; p_mr = mem_read; p_mw = mem_write;
      end else begin
        p_alu = 0; p_dack = 0; p_req = 0; p_iack = 0; p_mr = 0; p_mw = 0; req_run = 0;
      end
    end
  end

  task automatic start_prog(input logic [7:0] b, output int c0);
    @(negedge clk); #2;
    c0 = cyc;
    base_pc = b;
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = n_done;
    for (int i = 0; i < budget && n_done == n0; i++) begin @(negedge clk); #2; end
    checks++;
    if (n_done == n0) begin failures++; $display("FAIL wait_done: no done pulse within %0d cycles", budget); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({imem_req, alu_enable, alu_op, mem_read, mem_write, reg_write, busy, done} !== 9'h0) begin
      failures++; $display("FAIL reset_strobes: got %b expected 0", {imem_req, alu_enable, alu_op, mem_read, mem_write, reg_write, busy, done});
    end
    checks++;
    if ({pc, imem_addr, instr} !== 32'h0) begin
      failures++; $display("FAIL reset_regs: got %h expected 0", {pc, imem_addr, instr});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got busy=%b req=%b expected 0 0", busy, imem_req);
    end
  endtask

  task automatic test_alu();
    int c0;
    imem[8'h10] = ins(OP_ADD); imem[8'h11] = ins(OP_SUB);
    imem[8'h12] = ins(OP_AND); imem[8'h13] = ins(OP_HALT);
    idelay = 0; ddelay = 0;
    begin
      int a0, r0;
      a0 = n_alu; r0 = n_rw;
      start_prog(8'h10, c0);
      checks++;
      if (imem_req !== 1'b1 || busy !== 1'b1 || imem_addr !== 8'h10) begin
        failures++; $display("FAIL alu_first_fetch: got req=%b busy=%b addr=%h expected 1 1 10", imem_req, busy, imem_addr);
      end
      wait_done(40);
      checks++;
      if (done_cyc - c0 !== 15) begin failures++; $display("FAIL alu_done_cycle: got %0d expected 15", done_cyc - c0); end
      checks++;
      if (n_alu - a0 !== 3) begin failures++; $display("FAIL alu_count: got %0d expected 3", n_alu - a0); end
      checks++;
      if (op_log !== 6'b00_01_10) begin failures++; $display("FAIL alu_ops: got %b expected 000110", op_log); end
      checks++;
      if (n_rw - r0 !== 3) begin failures++; $display("FAIL alu_reg_write: got %0d expected 3", n_rw - r0); end
    end
    @(negedge clk); #2;
    checks++;
    if (pc !== 8'h13 || busy !== 1'b0) begin
      failures++; $display("FAIL alu_final: got pc=%h busy=%b expected 13 0", pc, busy);
    end
  endtask

  task automatic test_load_store();
    int c0, m0, r0;
    imem[8'h20] = ins(OP_LOAD); imem[8'h21] = ins(OP_HALT);
    idelay = 0; ddelay = 3;
    m0 = n_mr; r0 = n_rw;
    start_prog(8'h20, c0);
    wait_done(40);
    checks++;
    if (n_mr - m0 !== 4) begin failures++; $display("FAIL load_read_cycles: got %0d expected 4", n_mr - m0); end
    checks++;
    if (n_rw - r0 !== 1) begin failures++; $display("FAIL load_reg_write: got %0d expected 1", n_rw - r0); end
    checks++;
    if (done_cyc - c0 !== 10) begin failures++; $display("FAIL load_done_cycle: got %0d expected 10", done_cyc - c0); end
    @(negedge clk); #2;
    checks++;
    if (pc !== 8'h21) begin failures++; $display("FAIL load_pc: got %h expected 21", pc); end

    imem[8'h28] = ins(OP_STORE); imem[8'h29] = ins(OP_HALT);
    ddelay = 2;
    m0 = n_mw; r0 = n_rw;
    start_prog(8'h28, c0);
    wait_done(40);
    checks++;
    if (n_mw - m0 !== 3) begin failures++; $display("FAIL store_write_cycles: got %0d expected 3", n_mw - m0); end
    checks++;
    if (n_rw - r0 !== 0) begin failures++; $display("FAIL store_reg_write: got %0d expected 0", n_rw - r0); end
    checks++;
    if (done_cyc - c0 !== 8) begin failures++; $display("FAIL store_done_cycle: got %0d expected 8", done_cyc - c0); end
    @(negedge clk); #2;
    checks++;
    if (pc !== 8'h29) begin failures++; $display("FAIL store_pc: got %h expected 29", pc); end
    ddelay = 0;
  endtask

  task automatic test_imem_wait();
    int c0, a0, m0;
    imem[8'h30] = ins(OP_ADD); imem[8'h31] = ins(OP_HALT);
    idelay = 5; dspur = 1'b1;
    a0 = n_alu; m0 = n_mr + n_mw;
    start_prog(8'h30, c0);
    wait_done(60);
    dspur = 1'b0;
    checks++;
    if (last_req_run !== 6) begin failures++; $display("FAIL imem_req_length: got %0d expected 6", last_req_run); end
    checks++;
    if (done_cyc - c0 !== 17) begin failures++; $display("FAIL imem_done_cycle: got %0d expected 17", done_cyc - c0); end
    checks++;
    if (n_alu - a0 !== 1 || (n_mr + n_mw) - m0 !== 0) begin
      failures++; $display("FAIL imem_spurious: got alu=%0d mem=%0d expected 1 0", n_alu - a0, (n_mr + n_mw) - m0);
    end
    @(negedge clk); #2;
    checks++;
    if (pc !== 8'h31) begin failures++; $display("FAIL imem_pc: got %h expected 31", pc); end
    idelay = 0;
  endtask

  task automatic test_wrap_nop();
    int c0, s0;
    imem[8'hFF] = ins(OP_NOP); imem[8'h00] = ins(OP_HALT);
    s0 = n_alu + n_rw + n_mr + n_mw;
    start_prog(8'hFF, c0);
    wait_done(40);
    checks++;
    if (fa1 !== 8'hFF || fa0 !== 8'h00) begin failures++; $display("FAIL wrap_fetch_addr: got %h %h expected ff 00", fa1, fa0); end
    checks++;
    if ((n_alu + n_rw + n_mr + n_mw) - s0 !== 0) begin failures++; $display("FAIL nop_strobes: got %0d expected 0", (n_alu + n_rw + n_mr + n_mw) - s0); end
    checks++;
    if (done_cyc - c0 !== 5) begin failures++; $display("FAIL wrap_done_cycle: got %0d expected 5", done_cyc - c0); end
    @(negedge clk); #2;
    checks++;
    if (pc !== 8'h00) begin failures++; $display("FAIL wrap_pc: got %h expected 00", pc); end
  endtask

  task automatic test_reset_mid();
    int c0, bad;
    imem[8'h40] = ins(OP_STORE);
    ddelay = 20;
    start_prog(8'h40, c0);
    for (int i = 0; i < 10 && mem_write !== 1'b1; i++) begin @(negedge clk); #2; end
    checks++;
    if (mem_write !== 1'b1) begin failures++; $display("FAIL midreset_setup: got mem_write=%b expected 1", mem_write); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0) begin failures++; $display("FAIL midreset_async: got mem_write=%b expected 0", mem_write); end
    checks++;
    if ({imem_req, alu_enable, alu_op, mem_read, reg_write, busy, done, pc, instr} !== 32'h0) begin
      failures++; $display("FAIL midreset_outputs: got %h expected 0", {imem_req, alu_enable, alu_op, mem_read, reg_write, busy, done, pc, instr});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ddelay = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      if (busy !== 1'b0 || imem_req !== 1'b0 || mem_write !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL midreset_stays_idle: got %0d busy cycles expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    int c0;
    imem[8'h50] = ins(OP_ADD); imem[8'h51] = ins(OP_HALT);
    imem[8'h70] = ins(OP_HALT);
    imem[8'h60] = ins(OP_ADD); imem[8'h61] = ins(OP_HALT);
    start_prog(8'h50, c0);
    @(negedge clk); #2;
    base_pc = 8'h70; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    wait_done(40);
    checks++;
    if (done_cyc - c0 !== 7) begin failures++; $display("FAIL busy_start_done_cycle: got %0d expected 7", done_cyc - c0); end
    checks++;
    if (pc !== 8'h51) begin failures++; $display("FAIL busy_start_no_reload: got pc=%h expected 51", pc); end
    base_pc = 8'h60; start = 1'b1;
    @(negedge clk); #2;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL halt_start_ignored: got busy=%b expected 0", busy); end
    c0 = cyc;
    @(negedge clk); #2;
    start = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h60) begin
      failures++; $display("FAIL b2b_restart: got req=%b addr=%h expected 1 60", imem_req, imem_addr);
    end
    wait_done(40);
    checks++;
    if (done_cyc - c0 !== 7) begin failures++; $display("FAIL b2b_done_cycle: got %0d expected 7", done_cyc - c0); end
    @(negedge clk); #2;
    checks++;
    if (pc !== 8'h61 || busy !== 1'b0) begin failures++; $display("FAIL b2b_final: got pc=%h busy=%b expected 61 0", pc, busy); end
  endtask

  task automatic test_invariants();
    checks++;
    if (n_rw_bad !== 0) begin failures++; $display("FAIL reg_write_timing: got %0d misplaced expected 0", n_rw_bad); end
    checks++;
    if (n_bad !== 0) begin failures++; $display("FAIL strobe_exclusion: got %0d violations expected 0", n_bad); end
    checks++;
    if (unstable !== 0) begin failures++; $display("FAIL request_stability: got %0d drops expected 0", unstable); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = ins(OP_HALT);
    test_reset();
    test_alu();
    test_load_store();
    test_imem_wait();
    test_wrap_nop();
    test_reset_mid();
    test_back_to_back();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
